// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: default timing and button indices.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat on up/down).
package btn_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;    // 5 ms @ 100 MHz
  localparam int CNT_W_DEF           = 19;
  localparam int REPEAT_DELAY_DEF    = 50000000;  // 500 ms before auto-repeat
  localparam int REPEAT_PERIOD_DEF   = 20000000;  // 200 ms between repeats

  // Button indices; lower index wins when several buttons pulse together.
  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_U   = 2;
  localparam int BTN_D   = 3;
  localparam int NUM_BTN = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/btn_debounce.sv
// One raw input: 2-flop synchronizer, hold-time debounce counter, stable level
// and a one-cycle strobe on every accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept a new level only after it holds DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise   <= 1'b0;
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q[1];
        rise   <= sync_q[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Guessing-game front end: debounces four buttons and the enable switch, emits
// one-cycle press pulses (priority left > right > up > down, gated by enable).
// Optional feature macro: BTN_REPEAT_EN adds auto-repeat pulses on up/down.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_l,
  input  logic btn_r,
  input  logic btn_u,
  input  logic btn_d,
  input  logic sw_en,
  output logic left,
  output logic right,
  output logic up,
  output logic down,
  output logic enable
);

  // Elaboration-time sanity checks on the timing parameters.
  if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  btn_vec_t btn_raw, btn_stable, btn_rise;
  btn_vec_t req, gnt, pulse_q;
  logic     en_rise_unused;

  assign btn_raw = {btn_d, btn_u, btn_r, btn_l};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (btn_raw[g]),
      .stable (btn_stable[g]),
      .rise   (btn_rise[g])
    );
  end

  // The enable switch is a level; its stable register drives enable directly.
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_en (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sw_en),
    .stable (enable),
    .rise   (en_rise_unused)
  );

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  // Slot 0 = up, slot 1 = down; left/right never repeat.
  logic [1:0]            rpt_act, rpt_first, rpt_fire;
  logic [1:0][RPT_W-1:0] rpt_cnt;
  btn_vec_t              press_gnt, rpt_req;

  assign press_gnt = gnt & btn_rise & {NUM_BTN{enable}};
  assign rpt_req   = {rpt_fire, 2'b00};

  for (genvar k = 0; k < 2; k++) begin : g_rpt
    localparam int IDX = BTN_U + k;

    // Fire once the hold counter reaches the delay (first) or the period (after).
    always_comb begin
      rpt_fire[k] = rpt_act[k] && btn_stable[IDX] && enable &&
                    (rpt_cnt[k] == (rpt_first[k] ? DELAY_LAST : PERIOD_LAST));
    end

    // Arm on the granted press pulse, count while held, drop on release or disable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_act[k]   <= 1'b0;
        rpt_first[k] <= 1'b0;
        rpt_cnt[k]   <= '0;
      end else if (!btn_stable[IDX] || !enable) begin
        rpt_act[k] <= 1'b0;
        rpt_cnt[k] <= '0;
      end else if (press_gnt[IDX]) begin
        rpt_act[k]   <= 1'b1;
        rpt_first[k] <= 1'b1;
        rpt_cnt[k]   <= '0;
      end else if (rpt_fire[k]) begin
        rpt_first[k] <= 1'b0;
        rpt_cnt[k]   <= '0;
      end else if (rpt_act[k]) begin
        rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
      end
    end
  end

  // Press strobes and repeat requests compete in the same priority chain.
  always_comb begin
    req = btn_rise | rpt_req;
    gnt = req & (~req + btn_vec_t'(1));
  end
`else
  logic btn_stable_unused;
  assign btn_stable_unused = ^btn_stable;

  // Lowest set index wins; the rest are dropped.
  always_comb begin
    req = btn_rise;
    gnt = req & (~req + btn_vec_t'(1));
  end
`endif

  // Registered one-hot pulse, suppressed whenever enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_q <= '0;
    else        pulse_q <= enable ? gnt : '0;
  end

  assign left  = pulse_q[BTN_L];
  assign right = pulse_q[BTN_R];
  assign up    = pulse_q[BTN_U];
  assign down  = pulse_q[BTN_D];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;
  import btn_pkg::*;

`ifdef BTN_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       sw_en = 1'b0;
  logic       left, right, up, down, enable;
  logic [3:0] pulses;

  int n_vec = 0;
  int n_bad = 0;

  assign pulses = {down, up, right, left};

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .CNT_W(3), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_l(btn[BTN_L]), .btn_r(btn[BTN_R]), .btn_u(btn[BTN_U]), .btn_d(btn[BTN_D]),
    .sw_en(sw_en),
    .left(left), .right(right), .up(up), .down(down), .enable(enable)
  );

  typedef struct {
    string      name;
    logic [3:0] mask;      // buttons raised at cycle 0
    int         hold;      // raw high for cycles 0..hold-1
    logic [3:0] exp_mask;  // expected pulse pattern
    int         exp_cyc;   // cycle of the press pulse, -1 for none
    int         rpt_until; // last repeat cycle when repeat is built, 0 for none
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_at(input vec_t v, input int c);
    if (c == v.exp_cyc) return v.exp_mask;
    if (RPT && v.rpt_until > 0 && c >= v.exp_cyc + 8 && c <= v.rpt_until &&
        ((c - v.exp_cyc - 8) % 3) == 0) return v.exp_mask;
    return 4'b0;
  endfunction

  task automatic run_vec(input vec_t v);
    btn = v.mask;
    for (int c = 1; c <= v.hold + 10; c++) begin
      tick();
      if (c == v.hold) btn = 4'b0;
      chk($sformatf("%s c%0d", v.name, c), 32'(pulses), 32'(exp_at(v, c)));
    end
    chk({v.name, " enable"}, 32'(enable), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"right_hold20",  4'b0010, 20, 4'b0010,  7, 0};
    vecs[1] = '{"left_glitch3",  4'b0001,  3, 4'b0000, -1, 0};
    vecs[2] = '{"left_hold4",    4'b0001,  4, 4'b0001,  7, 0};
    vecs[3] = '{"left_down_sim", 4'b1001, 12, 4'b0001,  7, 0};
    vecs[4] = '{"right_up_sim",  4'b0110, 10, 4'b0010,  7, 0};
    vecs[5] = '{"up_hold23",     4'b0100, 23, 4'b0100,  7, 27};
    vecs[6] = '{"down_hold23",   4'b1000, 23, 4'b1000,  7, 27};
    vecs[7] = '{"left_hold23",   4'b0001, 23, 4'b0001,  7, 0};

    // Reset state
    repeat (3) tick();
    chk("reset outputs", 32'({pulses, enable}), 32'd0);
    rst_n = 1'b1;
    sw_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("enable rise c%0d", c), 32'(enable), 32'(c >= 6));
      chk($sformatf("idle pulses c%0d", c), 32'(pulses), 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Enable gating: press while disabled, then raise enable while held.
    sw_en = 1'b0;
    repeat (10) tick();
    chk("enable low", 32'(enable), 32'd0);
    btn = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("gated up c%0d", c), 32'(pulses), 32'd0);
    end
    sw_en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("en raise held c%0d", c), 32'(pulses), 32'd0);
      chk($sformatf("en raise lvl c%0d", c), 32'(enable), 32'(c >= 6));
    end
    btn = 4'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("up release c%0d", c), 32'(pulses), 32'd0);
    end
    run_vec('{"up_repress", 4'b0100, 10, 4'b0100, 7, 0});

    // Reset mid-debounce of btn_d with the button still held afterwards.
    btn = 4'b1000;
    tick(); chk("rst pre c1", 32'(pulses), 32'd0);
    tick(); chk("rst pre c2", 32'(pulses), 32'd0);
    tick();
    rst_n = 1'b0;
    #1 chk("rst asserted", 32'({pulses, enable}), 32'd0);
    tick(); chk("rst held c4", 32'({pulses, enable}), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk($sformatf("post rst pulse c%0d", c), 32'(pulses), (c == 7) ? 32'h8 : 32'h0);
      chk($sformatf("post rst en c%0d", c), 32'(enable), 32'(c >= 6));
    end
    btn = 4'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("final release c%0d", c), 32'(pulses), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
